// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle HI/LO multiply/divide unit; optional restoring
//            divider compiled in with `define MULDIV_DIV_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module Mul (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] p
);
   logic [63:0] w_ax;
   logic [63:0] w_bx;

   assign w_ax = {{32{a[31]}}, a};
   assign w_bx = {{32{b[31]}}, b};
   assign p    = w_ax * w_bx;
endmodule

module muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;
`endif

   logic [1:0]  r_state;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [1:0]  r_op;
   logic [63:0] w_sprod;
   logic [63:0] w_prod;

   Mul u_mul (.a(r_a), .b(r_b), .p(w_sprod));

   // Unsigned product from the signed one: add back the weight of each MSB.
   always_comb begin
      w_prod = w_sprod;
      if (r_op[0]) begin
         if (r_a[31]) w_prod = w_prod + {r_b, 32'b0};
         if (r_b[31]) w_prod = w_prod + {r_a, 32'b0};
      end
   end

`ifdef MULDIV_DIV_EN
   logic [4:0]  r_count;
   logic [31:0] r_rem;
   logic [31:0] r_quot;
   logic [31:0] r_dvsr;
   logic [31:0] w_amag;
   logic [31:0] w_bmag;
   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic        w_sa;
   logic        w_sb;
   logic [31:0] w_q_fix;
   logic [31:0] w_r_fix;

   // 0x80000000 maps to itself, which read unsigned is the magnitude 2^31.
   assign w_amag  = (!op[0] && a[31]) ? (~a + 32'd1) : a;
   assign w_bmag  = (!op[0] && b[31]) ? (~b + 32'd1) : b;
   assign w_shift = {r_rem, r_quot[31]};
   assign w_diff  = w_shift - {1'b0, r_dvsr};
   assign w_sa    = !r_op[0] && r_a[31];
   assign w_sb    = !r_op[0] && r_b[31];
   assign w_q_fix = (w_sa ^ w_sb) ? (~r_quot + 32'd1) : r_quot;
   assign w_r_fix = w_sa ? (~r_rem + 32'd1) : r_rem;
`endif

   assign busy = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_op    <= 2'd0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         done    <= 1'b0;
`ifdef MULDIV_DIV_EN
         r_count <= 5'd0;
         r_rem   <= 32'd0;
         r_quot  <= 32'd0;
         r_dvsr  <= 32'd0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_op    <= op;
                  r_state <= S_MUL;
`ifdef MULDIV_DIV_EN
                  if (op[1]) begin
                     r_state <= S_DIV;
                     r_count <= 5'd0;
                     r_rem   <= 32'd0;
                     r_quot  <= w_amag;
                     r_dvsr  <= w_bmag;
                  end
`endif
               end
            end
            S_MUL: begin
               // A divide op lands here only when the divider is absent.
               if (!r_op[1]) begin
                  hi <= w_prod[63:32];
                  lo <= w_prod[31:0];
               end
               done    <= 1'b1;
               r_state <= S_IDLE;
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
               if (!w_diff[32]) begin
                  r_rem  <= w_diff[31:0];
                  r_quot <= {r_quot[30:0], 1'b1};
               end else begin
                  r_rem  <= w_shift[31:0];
                  r_quot <= {r_quot[30:0], 1'b0};
               end
               r_count <= r_count + 5'd1;
               if (r_count == 5'd31) r_state <= S_FIX;
            end
            S_FIX: begin
               if (r_b == 32'd0) begin
                  hi <= r_a;
                  lo <= 32'hFFFF_FFFF;
               end else begin
                  hi <= w_r_fix;
                  lo <= w_q_fix;
               end
               done    <= 1'b1;
               r_state <= S_IDLE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire
